// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the EX-stage forwarding scoreboard.
// Entry fields are sized for the largest supported configuration
// (register address width up to FWD_RD_W, positions up to 2**FWD_POS_W-1).
// Modules zero-extend their narrower fields into these.
package fwd_pkg;

  localparam int FWD_RD_W  = 8;
  localparam int FWD_POS_W = 4;

  // Select value meaning "use register-file data".
  localparam logic [FWD_POS_W-1:0] FWD_SEL_RF    = 4'd0;
  // Scoreboard positions after EX.
  localparam logic [FWD_POS_W-1:0] FWD_POS_MEM   = 4'd1;
  localparam logic [FWD_POS_W-1:0] FWD_POS_WB    = 4'd2;
  localparam logic [FWD_POS_W-1:0] FWD_POS_RFILE = 4'd3;

  typedef struct packed {
    logic                 valid;
    logic [FWD_RD_W-1:0]  rd;
    logic [FWD_POS_W-1:0] ready_pos;
  } fwd_entry_t;

  // Bound the first forwardable position to 1..max_pos.
  function automatic logic [FWD_POS_W-1:0] fwd_clamp_ready(
    input logic [FWD_POS_W-1:0] rdy,
    input logic [FWD_POS_W-1:0] max_pos
  );
    logic [FWD_POS_W-1:0] res;
    if (rdy == FWD_SEL_RF) begin
      res = FWD_POS_MEM;
    end else if (rdy > max_pos) begin
      res = max_pos;
    end else begin
      res = rdy;
    end
    return res;
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match: priority match of one source operand against the
// scoreboard. The lowest-numbered (youngest) matching entry wins; if its
// result is not yet forwardable at that position a hazard is raised.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int NUM_FWD_STAGES = 3,
  parameter int REG_AW         = 5,
  parameter int SEL_W          = 2
) (
  input  fwd_entry_t [NUM_FWD_STAGES:1] entries_i,
  input  logic [REG_AW-1:0]             rs_i,
  input  logic                          rs_used_i,
  output logic [SEL_W-1:0]              sel_o,
  output logic                          hazard_o
);

  logic [FWD_RD_W-1:0]  rs_ext_s;
  logic                 hit_s;
  logic [FWD_POS_W-1:0] win_pos_s;
  logic [FWD_POS_W-1:0] win_ready_s;

  assign rs_ext_s = FWD_RD_W'(rs_i);

  // Scan oldest to youngest so the youngest matching writer overwrites.
  always_comb begin
    hit_s       = 1'b0;
    win_pos_s   = FWD_SEL_RF;
    win_ready_s = FWD_SEL_RF;
    for (int p = NUM_FWD_STAGES; p >= 1; p--) begin
      if (rs_used_i && (rs_ext_s != '0) && entries_i[p].valid &&
          (entries_i[p].rd == rs_ext_s)) begin
        hit_s       = 1'b1;
        win_pos_s   = FWD_POS_W'(p);
        win_ready_s = entries_i[p].ready_pos;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Turn the winning entry into a forward select or a not-ready hazard.
  always_comb begin
    sel_o    = SEL_W'(FWD_SEL_RF);
    hazard_o = 1'b0;
    if (!hit_s) begin
      sel_o = SEL_W'(FWD_SEL_RF);
    end else if (win_pos_s >= win_ready_s) begin
      sel_o = SEL_W'(win_pos_s);
    end else begin
      hazard_o = 1'b1;
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: operand forwarding and hazard unit for the EX stage.
// In-flight writers are tracked in an internal shift-register scoreboard.
// Optional feature macro: FWD_PERF_CNT_EN adds a saturating stall counter
// on stall_cnt_o (width CNT_W).
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 3,
  parameter int REG_AW         = 5,
  parameter int SEL_W          = $clog2(NUM_FWD_STAGES + 1)
`ifdef FWD_PERF_CNT_EN
  ,
  parameter int CNT_W          = 32
`endif
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ex_valid_i,
  input  logic [REG_AW-1:0]              ex_rd_i,
  input  logic                           ex_regwrite_i,
  input  logic [SEL_W-1:0]               ex_ready_stage_i,
  input  logic [NUM_SRC-1:0][REG_AW-1:0] ex_rs_i,
  input  logic [NUM_SRC-1:0]             ex_rs_used_i,
  input  logic                           flush_i,
  output logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel_o,
  output logic                           stall_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]               stall_cnt_o
`endif
);

  fwd_entry_t [NUM_FWD_STAGES:1] sb_q;
  fwd_entry_t [NUM_FWD_STAGES:1] sb_d;
  fwd_entry_t                    ex_entry_s;
  logic [NUM_SRC-1:0]            hazard_s;
  logic                          stall_s;

  // Qualified EX writer as it would enter position 1.
  always_comb begin
    ex_entry_s.valid     = ex_valid_i & ex_regwrite_i & (ex_rd_i != '0);
    ex_entry_s.rd        = FWD_RD_W'(ex_rd_i);
    ex_entry_s.ready_pos = fwd_clamp_ready(FWD_POS_W'(ex_ready_stage_i),
                                           FWD_POS_W'(NUM_FWD_STAGES));
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_match #(
      .NUM_FWD_STAGES (NUM_FWD_STAGES),
      .REG_AW         (REG_AW),
      .SEL_W          (SEL_W)
    ) u_match (
      .entries_i (sb_q),
      .rs_i      (ex_rs_i[g]),
      .rs_used_i (ex_rs_used_i[g]),
      .sel_o     (fwd_sel_o[g]),
      .hazard_o  (hazard_s[g])
    );
  end

  // A flushed instruction never stalls.
  assign stall_s = (|hazard_s) & ex_valid_i & ~flush_i;
  assign stall_o = stall_s;

  // Advance the scoreboard; a stalled or flushed EX slot becomes a bubble.
  always_comb begin
    sb_d = sb_q;
    if (!stall_s && !flush_i) begin
      sb_d[1] = ex_entry_s;
    end else begin
      sb_d[1] = '0;
    end
    for (int k = 2; k <= NUM_FWD_STAGES; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count stall cycles, holding at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_s && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed self-checking bench for fwd_scoreboard.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. With FWD_PERF_CNT_EN defined the counter is built 2 bits
// wide so saturation is reachable.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  localparam int NUM_SRC = 2;
  localparam int NFS     = 3;
  localparam int REG_AW  = 5;
  localparam int SEL_W   = 2;

  logic                           clk;
  logic                           rst_n;
  logic                           ex_valid_i;
  logic [REG_AW-1:0]              ex_rd_i;
  logic                           ex_regwrite_i;
  logic [SEL_W-1:0]               ex_ready_stage_i;
  logic [NUM_SRC-1:0][REG_AW-1:0] ex_rs_i;
  logic [NUM_SRC-1:0]             ex_rs_used_i;
  logic                           flush_i;
  logic [NUM_SRC-1:0][SEL_W-1:0]  fwd_sel_o;
  logic                           stall_o;
`ifdef FWD_PERF_CNT_EN
  logic [1:0]                     stall_cnt_o;
`endif

  int tests;
  int fails;

  fwd_scoreboard #(
    .NUM_SRC        (NUM_SRC),
    .NUM_FWD_STAGES (NFS),
    .REG_AW         (REG_AW),
    .SEL_W          (SEL_W)
`ifdef FWD_PERF_CNT_EN
    ,
    .CNT_W          (2)
`endif
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_valid_i       (ex_valid_i),
    .ex_rd_i          (ex_rd_i),
    .ex_regwrite_i    (ex_regwrite_i),
    .ex_ready_stage_i (ex_ready_stage_i),
    .ex_rs_i          (ex_rs_i),
    .ex_rs_used_i     (ex_rs_used_i),
    .flush_i          (flush_i),
    .fwd_sel_o        (fwd_sel_o),
    .stall_o          (stall_o)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cnt_o      (stall_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one EX slot: valid, rd, regwrite, ready stage, rs0, rs1, used mask, flush.
  task automatic drive(input logic v, input logic [4:0] rd, input logic rw,
                       input logic [1:0] rdy, input logic [4:0] rs0,
                       input logic [4:0] rs1, input logic [1:0] used,
                       input logic fl);
    ex_valid_i       = v;
    ex_rd_i          = rd;
    ex_regwrite_i    = rw;
    ex_ready_stage_i = rdy;
    ex_rs_i[0]       = rs0;
    ex_rs_i[1]       = rs1;
    ex_rs_used_i     = used;
    flush_i          = fl;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 5'd0, 1'b0, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
      nxt();
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Load x6 followed by a user of x6 on rs2; checks the single stall cycle.
  task automatic load_use(input string tag);
    drive(1'b1, 5'd6, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd0, 5'd6, 2'b10, 1'b0);
    smp();
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd1);
    nxt();
    smp();
    chk({tag, "_released"}, {31'd0, stall_o}, 32'd0);
    nxt();
    idle(3);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    #2;
    chk("reset_sel0",  {30'd0, fwd_sel_o[0]}, 32'd0);
    chk("reset_sel1",  {30'd0, fwd_sel_o[1]}, 32'd0);
    chk("reset_stall", {31'd0, stall_o}, 32'd0);
    nxt();
    rst_n = 1'b1;
    idle(1);

    // ALU x5 then immediate user: forward from MEM.
    drive(1'b1, 5'd5, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd5, 5'd0, 2'b01, 1'b0);
    smp();
    chk("alu_d1_sel",   {30'd0, fwd_sel_o[0]}, 32'(FWD_POS_MEM));
    chk("alu_d1_stall", {31'd0, stall_o}, 32'd0);
    nxt();
    idle(3);

    // One instruction in between: forward from WB.
    drive(1'b1, 5'd5, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd9, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd5, 5'd0, 2'b01, 1'b0);
    smp();
    chk("alu_d2_sel", {30'd0, fwd_sel_o[0]}, 32'(FWD_POS_WB));
    nxt();
    idle(3);

    // Two in between: forward from register-file write-through.
    drive(1'b1, 5'd5, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd9, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd10, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd5, 5'd0, 2'b01, 1'b0);
    smp();
    chk("alu_d3_sel", {30'd0, fwd_sel_o[0]}, 32'(FWD_POS_RFILE));
    nxt();
    idle(3);

    // Load-use on rs2: one stall, then forward from WB.
    drive(1'b1, 5'd6, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd0, 5'd6, 2'b10, 1'b0);
    smp();
    chk("lu_stall",     {31'd0, stall_o}, 32'd1);
    chk("lu_sel_hold",  {30'd0, fwd_sel_o[1]}, 32'd0);
    nxt();
    smp();
    chk("lu_stall_end", {31'd0, stall_o}, 32'd0);
    chk("lu_sel_wb",    {30'd0, fwd_sel_o[1]}, 32'd2);
    nxt();
    idle(3);

    // Two writers of x7: youngest (position 1) wins; rs unused gives 0.
    drive(1'b1, 5'd7, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd7, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd7, 5'd7, 2'b01, 1'b0);
    smp();
    chk("dup_youngest", {30'd0, fwd_sel_o[0]}, 32'd1);
    chk("unused_rs",    {30'd0, fwd_sel_o[1]}, 32'd0);
    nxt();
    idle(3);

    // x0 writer never matches.
    drive(1'b1, 5'd0, 1'b1, 2'd1, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd0, 5'd0, 2'b11, 1'b0);
    smp();
    chk("x0_sel0", {30'd0, fwd_sel_o[0]}, 32'd0);
    chk("x0_sel1", {30'd0, fwd_sel_o[1]}, 32'd0);
    nxt();
    idle(3);

    // ready stage 0 clamps to 1: no stall, forward from MEM.
    drive(1'b1, 5'd11, 1'b1, 2'd0, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd11, 5'd0, 2'b01, 1'b0);
    smp();
    chk("clamp0_stall", {31'd0, stall_o}, 32'd0);
    chk("clamp0_sel",   {30'd0, fwd_sel_o[0]}, 32'd1);
    nxt();
    idle(3);

    // Late result ready at position 3: two stall cycles then forward from 3.
    drive(1'b1, 5'd12, 1'b1, 2'd3, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd12, 5'd0, 2'b01, 1'b0);
    smp();
    chk("late_stall1", {31'd0, stall_o}, 32'd1);
    nxt();
    smp();
    chk("late_stall2", {31'd0, stall_o}, 32'd1);
    nxt();
    smp();
    chk("late_go",  {31'd0, stall_o}, 32'd0);
    chk("late_sel", {30'd0, fwd_sel_o[0]}, 32'd3);
    nxt();
    idle(3);

    // Load-use with flush: no stall, bubble enters position 1.
    drive(1'b1, 5'd6, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd9, 1'b1, 2'd1, 5'd0, 5'd6, 2'b10, 1'b1);
    smp();
    chk("flush_stall", {31'd0, stall_o}, 32'd0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd9, 5'd6, 2'b11, 1'b0);
    smp();
    chk("flush_bubble", {30'd0, fwd_sel_o[0]}, 32'd0);
    chk("flush_load",   {30'd0, fwd_sel_o[1]}, 32'd2);
    chk("flush_after",  {31'd0, stall_o}, 32'd0);
    nxt();
    idle(3);

    // Asynchronous reset in the middle of a load-use stall.
    drive(1'b1, 5'd6, 1'b1, 2'd2, 5'd0, 5'd0, 2'b00, 1'b0);
    nxt();
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd6, 5'd6, 2'b11, 1'b0);
    #2;
    chk("prerst_stall", {31'd0, stall_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_sel0",  {30'd0, fwd_sel_o[0]}, 32'd0);
    chk("rst_sel1",  {30'd0, fwd_sel_o[1]}, 32'd0);
`ifdef FWD_PERF_CNT_EN
    chk("rst_cnt", {30'd0, stall_cnt_o}, 32'd0);
`endif
    nxt();
    rst_n = 1'b1;
    drive(1'b1, 5'd0, 1'b0, 2'd1, 5'd6, 5'd0, 2'b01, 1'b0);
    smp();
    chk("post_rst_sel",   {30'd0, fwd_sel_o[0]}, 32'd0);
    chk("post_rst_stall", {31'd0, stall_o}, 32'd0);
    nxt();
    idle(3);

`ifdef FWD_PERF_CNT_EN
    // Three load-use hazards fill the 2-bit counter; a fourth saturates.
    chk("cnt_start", {30'd0, stall_cnt_o}, 32'd0);
    load_use("cnt_a");
    load_use("cnt_b");
    load_use("cnt_c");
    chk("cnt_three", {30'd0, stall_cnt_o}, 32'd3);
    load_use("cnt_d");
    chk("cnt_sat", {30'd0, stall_cnt_o}, 32'd3);
`else
    load_use("lu_repeat");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and hazard unit for the EX stage of the in-order RISC-V core. It tracks in-flight register writers internally in a shift-register scoreboard instead of taking per-stage Rd/RegWrite inputs. It produces a forwarding select for each of NUM_SRC source operands and a load-use/late-result stall. Forwarding depth, operand count and per-instruction result latency are all configurable.

## Interface
- NUM_SRC, 2, source operands checked per instruction
- NUM_FWD_STAGES, 3, tracked positions after EX (1=MEM, 2=WB, 3=RFile write-through)
- REG_AW, 5, register address width
- SEL_W, $clog2(NUM_FWD_STAGES+1), select width (derived)
- CNT_W, 32, stall counter width (FWD_PERF_CNT_EN only)

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid_i  in  1  valid instruction in EX
- ex_rd_i  in  REG_AW  destination of EX instruction
- ex_regwrite_i  in  1  EX instruction writes rd
- ex_ready_stage_i  in  SEL_W  first position where the result is forwardable (1=ALU, 2=load)
- ex_rs_i  in  NUM_SRC×REG_AW  source register addresses
- ex_rs_used_i  in  NUM_SRC  source actually read
- flush_i  in  1  squash EX instruction
- fwd_sel_o  out  NUM_SRC×SEL_W  0=register-file data, p=data from position p
- stall_o  out  1  hold IF/ID/EX, insert bubble into MEM
- stall_cnt_o  out  CNT_W  stall cycle count (FWD_PERF_CNT_EN only)

## Operation
- Scoreboard entries at positions 1..NUM_FWD_STAGES, each holding {valid, rd, ready_pos}.
- Entry writes are qualified: valid = ex_valid_i & ex_regwrite_i & (ex_rd_i≠0).
- ready_pos clamp: 0→1; values above NUM_FWD_STAGES→NUM_FWD_STAGES.
- Per source s: match = ex_rs_used_i[s] & ex_rs_i[s]≠0 & entry.valid & entry.rd==ex_rs_i[s].
- The lowest matching position (youngest writer) wins.
  - No match → fwd_sel_o[s]=0.
  - Winner p ≥ ready_pos → fwd_sel_o[s]=p.
  - Winner p < ready_pos → operand not ready; hazard raised, fwd_sel_o[s]=0.
- stall_o = OR of per-source hazards, gated by ex_valid_i & ~flush_i.
- Shift on every clock edge:
  - Position k+1 ← position k.
  - Position 1 ← EX entry when ~stall_o & ~flush_i; otherwise a bubble (valid=0).
  - Position NUM_FWD_STAGES is discarded.
- A stalled instruction re-evaluates the next cycle against the advanced scoreboard.

## Timing
- fwd_sel_o and stall_o are combinational from the inputs and the registered scoreboard; zero-cycle latency.
- An EX instruction becomes visible at position 1 in the cycle after the edge that accepts it.
- Load-use: exactly one stall cycle for the dependent instruction immediately following (load at position 1, ready_pos=2).
- flush_i with a hazard: flush dominates, stall_o=0, and a bubble enters position 1.
- Duplicate rd in several positions: youngest wins.
- rd=0 never matches.
- Reset (asynchronous, any time): all entries invalid; fwd_sel_o=0; stall_o=0; stall_cnt_o=0. Takes effect immediately, including mid-stall.

## Configuration
- FWD_PERF_CNT_EN defined:
  - stall_cnt_o is present.
  - It increments on each cycle with stall_o=1 and saturates at all ones.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package fwd_pkg holds:
  - fwd_entry_t struct {valid, rd, ready_pos}.
  - FWD_SEL_RF=0.
  - Position constants FWD_POS_MEM=1, FWD_POS_WB=2, FWD_POS_RFILE=3.
- Sub-module fwd_src_match: one instance per source operand. Priority match over the entry array; outputs sel and hazard.

## Test plan
- ALU x5 in EX, then dependent rs1=x5 next cycle → fwd_sel_o[0]=1, stall_o=0; with one instruction between → sel=2; with two between → sel=3.
- Load x6 (ready_stage=2), next instruction rs2=x6 → stall_o=1 for one cycle, then fwd_sel_o[1]=2.
- Two writers of x7 at positions 1 and 2, rs1=x7 → fwd_sel_o[0]=1; rs1=x0 with an x0 writer → sel=0.
- Load-use hazard with flush_i=1 in the same cycle → stall_o=0; next cycle position 1 is invalid.
- rst_n asserted mid-stall → stall_o=0 and all selects 0 immediately; after release, an independent instruction gives sel=0.
- FWD_PERF_CNT_EN: three separate load-use hazards → stall_cnt_o=3; preload near the maximum and verify saturation at all ones.
